// File: rtl/z80_accop_pkg.sv
// Shared types and constants for the Z80 accumulator/flag execution unit.
// Includes FSM states, opcode encodings and the F-register bit positions.
package z80_accop_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] OP_CPL    = 8'h2F;
    localparam logic [7:0] OP_SCF    = 8'h37;
    localparam logic [7:0] OP_CCF    = 8'h3F;
    localparam logic [7:0] OP_RLCA   = 8'h07;
    localparam logic [7:0] OP_RRCA   = 8'h0F;
    localparam logic [7:0] OP_RLA    = 8'h17;
    localparam logic [7:0] OP_RRA    = 8'h1F;
    localparam logic [7:0] OP_NEG    = 8'h44;
    localparam logic [7:0] OP_DAA    = 8'h27;
    localparam logic [7:0] PREFIX_ED = 8'hED;

    // Bit positions inside F = {S,Z,5,H,3,PV,N,C}
    localparam int FLAG_C_NUM  = 0;
    localparam int FLAG_N_NUM  = 1;
    localparam int FLAG_PV_NUM = 2;
    localparam int FLAG_3_NUM  = 3;
    localparam int FLAG_H_NUM  = 4;
    localparam int FLAG_5_NUM  = 5;
    localparam int FLAG_Z_NUM  = 6;
    localparam int FLAG_S_NUM  = 7;

    function automatic logic parity_even(input logic [7:0] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/z80_accop_compute.sv
// Combinational A/F result for CPL/SCF/CCF/rotates/NEG (and DAA when
// Z80_ACCOP_DAA_EN is defined); flags illegal encodings and passes A/F through.
module z80_accop_compute
    import z80_accop_pkg::*;
(
    input  logic [15:0] insn,
    input  logic [1:0]  len,
    input  logic [7:0]  a_in,
    input  logic [7:0]  f_in,
    output logic [7:0]  a_res,
    output logic [7:0]  f_res,
    output logic        illegal
);

    logic       is_rot;
    logic       cin;
    logic [7:0] neg_r;
`ifdef Z80_ACCOP_DAA_EN
    logic [7:0] corr;
`endif

    always_comb begin
        a_res   = a_in;
        f_res   = f_in;
        illegal = 1'b0;
        is_rot  = 1'b0;
        cin     = f_in[FLAG_C_NUM];
        neg_r   = 8'h00 - a_in;
`ifdef Z80_ACCOP_DAA_EN
        corr    = 8'h00;
`endif
        if (len == 2'd2) begin
            if (insn[15:8] == PREFIX_ED && insn[7:0] == OP_NEG) begin
                a_res              = neg_r;
                f_res              = neg_r & 8'hA8;
                f_res[FLAG_Z_NUM]  = (neg_r == 8'h00);
                f_res[FLAG_H_NUM]  = (a_in[3:0] != 4'h0);
                f_res[FLAG_PV_NUM] = (a_in == 8'h80);
                f_res[FLAG_N_NUM]  = 1'b1;
                f_res[FLAG_C_NUM]  = (a_in != 8'h00);
            end else begin
                illegal = 1'b1;
            end
        end else if (len == 2'd1) begin
            case (insn[7:0])
                OP_CPL: begin
                    a_res             = ~a_in;
                    f_res[FLAG_H_NUM] = 1'b1;
                    f_res[FLAG_N_NUM] = 1'b1;
                end
                OP_SCF: begin
                    f_res[FLAG_C_NUM] = 1'b1;
                    f_res[FLAG_H_NUM] = 1'b0;
                    f_res[FLAG_N_NUM] = 1'b0;
                    f_res[FLAG_5_NUM] = a_in[5];
                    f_res[FLAG_3_NUM] = a_in[3];
                end
                OP_CCF: begin
                    f_res[FLAG_H_NUM] = cin;
                    f_res[FLAG_C_NUM] = ~cin;
                    f_res[FLAG_N_NUM] = 1'b0;
                    f_res[FLAG_5_NUM] = a_in[5];
                    f_res[FLAG_3_NUM] = a_in[3];
                end
                OP_RLCA: begin
                    is_rot = 1'b1;
                    a_res  = {a_in[6:0], a_in[7]};
                    f_res[FLAG_C_NUM] = a_in[7];
                end
                OP_RRCA: begin
                    is_rot = 1'b1;
                    a_res  = {a_in[0], a_in[7:1]};
                    f_res[FLAG_C_NUM] = a_in[0];
                end
                OP_RLA: begin
                    is_rot = 1'b1;
                    a_res  = {a_in[6:0], cin};
                    f_res[FLAG_C_NUM] = a_in[7];
                end
                OP_RRA: begin
                    is_rot = 1'b1;
                    a_res  = {cin, a_in[7:1]};
                    f_res[FLAG_C_NUM] = a_in[0];
                end
`ifdef Z80_ACCOP_DAA_EN
                OP_DAA: begin
                    if (f_in[FLAG_H_NUM] || a_in[3:0] > 4'd9) corr = corr | 8'h06;
                    if (cin || a_in > 8'h99)                  corr = corr | 8'h60;
                    a_res = f_in[FLAG_N_NUM] ? (a_in - corr) : (a_in + corr);
                    f_res[FLAG_C_NUM]  = cin | (a_in > 8'h99);
                    f_res[FLAG_H_NUM]  = f_in[FLAG_N_NUM] ? (f_in[FLAG_H_NUM] & (a_in[3:0] < 4'd6))
                                                          : (a_in[3:0] > 4'd9);
                    f_res[FLAG_S_NUM]  = a_res[7];
                    f_res[FLAG_Z_NUM]  = (a_res == 8'h00);
                    f_res[FLAG_5_NUM]  = a_res[5];
                    f_res[FLAG_3_NUM]  = a_res[3];
                    f_res[FLAG_PV_NUM] = parity_even(a_res);
                end
`endif
                default: illegal = 1'b1;
            endcase
        end else begin
            illegal = 1'b1;
        end

        // Rotates share their H/N/5/3 treatment; S, Z, PV stay as they were
        if (is_rot) begin
            f_res[FLAG_H_NUM] = 1'b0;
            f_res[FLAG_N_NUM] = 1'b0;
            f_res[FLAG_5_NUM] = a_res[5];
            f_res[FLAG_3_NUM] = a_res[3];
        end
    end

endmodule

// File: rtl/z80_acc_op_unit.sv
// Multi-cycle accumulator/flag op unit: IDLE/EXEC/DONE FSM with M1 T-state counter.
// Optional DAA support is enabled by defining Z80_ACCOP_DAA_EN.
module z80_acc_op_unit
    import z80_accop_pkg::*;
#(
    parameter int M1_TCYCLES = 4,
    parameter int TC_W       = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [15:0]     op_insn,
    input  logic [1:0]      op_len,
    input  logic [15:0]     ip_in,
    input  logic [7:0]      a_in,
    input  logic [7:0]      f_in,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [7:0]      a_out,
    output logic [7:0]      f_out,
    output logic [15:0]     ip_out,
    output logic [TC_W-1:0] tcycles,
    output logic            illegal
);

    state_t          state_q, state_d;
    logic [TC_W-1:0] tcnt_q, tcnt_d;
    logic [1:0]      len_q, len_d;
    logic [7:0]      a_q, a_d, f_q, f_d;
    logic [15:0]     ip_q, ip_d;
    logic            ill_q, ill_d;

    logic [7:0]      a_res, f_res;
    logic            ill_res;
    logic            accept;
    logic [TC_W+2:0] tgt;

    z80_accop_compute u_compute (
        .insn    (op_insn),
        .len     (op_len),
        .a_in    (a_in),
        .f_in    (f_in),
        .a_res   (a_res),
        .f_res   (f_res),
        .illegal (ill_res)
    );

    assign op_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && res_ready);
    assign accept    = op_valid && op_ready;
    assign res_valid = (state_q == ST_DONE);
    assign tgt       = (TC_W+3)'(M1_TCYCLES) * {{(TC_W+1){1'b0}}, len_q};

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        len_d   = len_q;
        a_d     = a_q;
        f_d     = f_q;
        ip_d    = ip_q;
        ill_d   = ill_q;
        case (state_q)
            ST_EXEC: begin
                if ({3'b000, tcnt_q} >= tgt) state_d = ST_DONE;
                else                         tcnt_d  = tcnt_q + 1'b1;
            end
            ST_DONE: if (res_ready) state_d = ST_IDLE;
            default: ;
        endcase
        // A new request overrides the DONE->IDLE exit, giving back-to-back issue
        if (accept) begin
            state_d = ST_EXEC;
            tcnt_d  = TC_W'(1);
            len_d   = op_len;
            a_d     = a_res;
            f_d     = f_res;
            ill_d   = ill_res;
            ip_d    = ip_in + {14'd0, op_len};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tcnt_q  <= '0;
            len_q   <= '0;
            a_q     <= '0;
            f_q     <= '0;
            ip_q    <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            len_q   <= len_d;
            a_q     <= a_d;
            f_q     <= f_d;
            ip_q    <= ip_d;
            ill_q   <= ill_d;
        end
    end

    assign a_out   = a_q;
    assign f_out   = f_q;
    assign ip_out  = ip_q;
    assign tcycles = tcnt_q;
    assign illegal = ill_q;

endmodule

// File: tb/tb_z80_acc_op_unit.sv
// Randomized and directed bench for z80_acc_op_unit against an arithmetic reference model.
module tb_z80_acc_op_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_insn;
    logic [1:0]  op_len;
    logic [15:0] ip_in;
    logic [7:0]  a_in;
    logic [7:0]  f_in;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  a_out;
    logic [7:0]  f_out;
    logic [15:0] ip_out;
    logic [3:0]  tcycles;
    logic        illegal;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0]  exp_a, exp_f;
    logic        exp_ill;
    logic [15:0] exp_ip;
    int          exp_tc;

    always #5 clk = ~clk;

    z80_acc_op_unit dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_insn   (op_insn),
        .op_len    (op_len),
        .ip_in     (ip_in),
        .a_in      (a_in),
        .f_in      (f_in),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .a_out     (a_out),
        .f_out     (f_out),
        .ip_out    (ip_out),
        .tcycles   (tcycles),
        .illegal   (illegal)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the instruction semantics
    function automatic void model(input logic [15:0] insn, input logic [1:0] len,
                                  input logic [7:0] a, input logic [7:0] f,
                                  output logic [7:0] ra, output logic [7:0] rf,
                                  output logic ill);
        int av, fv, c, r, nc, lo, corr, nh, nn, hh;
        bit rot;
        av = a; fv = f; c = fv % 2; r = av; nc = c; rot = 0;
        ra = a; rf = f; ill = 1'b1;
        if (len == 2'd2 && insn[15:8] == 8'hED && insn[7:0] == 8'h44) begin
            r   = (256 - av) % 256;
            ra  = 8'(r);
            rf  = 8'((r & 'hA8) | (r == 0 ? 'h40 : 0) | ((av % 16) != 0 ? 'h10 : 0) |
                     (av == 128 ? 4 : 0) | 2 | (av != 0 ? 1 : 0));
            ill = 1'b0;
        end else if (len == 2'd1) begin
            ill = 1'b0;
            case (insn[7:0])
                8'h2F: begin ra = 8'(255 - av); rf = 8'((fv & 'hED) | 'h12); end
                8'h37: rf = 8'((fv & 'hC4) | (av & 'h28) | 1);
                8'h3F: rf = 8'((fv & 'hC4) | (av & 'h28) | (c * 16) | (1 - c));
                8'h07: begin rot = 1; r = (av * 2) % 256 + av / 128; nc = av / 128; end
                8'h0F: begin rot = 1; r = av / 2 + (av % 2) * 128;   nc = av % 2;   end
                8'h17: begin rot = 1; r = (av * 2) % 256 + c;        nc = av / 128; end
                8'h1F: begin rot = 1; r = av / 2 + c * 128;          nc = av % 2;   end
`ifdef Z80_ACCOP_DAA_EN
                8'h27: begin
                    lo = av % 16; nn = (fv / 2) % 2; hh = (fv / 16) % 2; corr = 0;
                    if (hh != 0 || lo > 9) corr += 6;
                    if (c != 0 || av > 153) corr += 96;
                    r  = (nn != 0) ? (av - corr + 256) % 256 : (av + corr) % 256;
                    nh = (nn != 0) ? ((hh != 0 && lo < 6) ? 1 : 0) : (lo > 9 ? 1 : 0);
                    ra = 8'(r);
                    rf = 8'((r & 'hA8) | (r == 0 ? 'h40 : 0) | nh * 16 |
                            (($countones(8'(r)) % 2 == 0) ? 4 : 0) | (fv & 2) |
                            ((c != 0 || av > 153) ? 1 : 0));
                end
`endif
                default: ill = 1'b1;
            endcase
            if (rot) begin
                ra = 8'(r);
                rf = 8'((fv & 'hC4) | (r & 'h28) | nc);
            end
        end
    endfunction

    // Present a request at the current cycle, take it on the next edge, then scramble inputs
    task automatic send(input logic [15:0] insn, input logic [1:0] len, input logic [15:0] ip,
                        input logic [7:0] a, input logic [7:0] f);
        op_insn = insn; op_len = len; ip_in = ip; a_in = a; f_in = f; op_valid = 1'b1;
        model(insn, len, a, f, exp_a, exp_f, exp_ill);
        exp_ip = ip + {14'd0, len};
        exp_tc = 4 * int'(len);
        #1;
        chk("op_ready_on_issue", {31'd0, op_ready}, 32'd1);
        @(posedge clk); #1;
        op_valid = 1'b0;
        op_insn  = 16'($urandom); op_len = 2'($urandom);
        ip_in    = 16'($urandom); a_in   = 8'($urandom); f_in = 8'($urandom);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_a"},   {24'd0, a_out},  {24'd0, exp_a});
        chk({tag, "_f"},   {24'd0, f_out},  {24'd0, exp_f});
        chk({tag, "_ip"},  {16'd0, ip_out}, {16'd0, exp_ip});
        chk({tag, "_tc"},  {28'd0, tcycles}, 32'(exp_tc));
        chk({tag, "_ill"}, {31'd0, illegal}, {31'd0, exp_ill});
    endtask

    task automatic wait_res(input string tag);
        int cnt = 0;
        while (res_valid !== 1'b1 && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk({tag, "_latency"}, 32'(cnt), 32'(exp_tc));
        check_outputs(tag);
    endtask

    task automatic hold(input int n);
        res_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, res_valid}, 32'd1);
            check_outputs("hold");
        end
    endtask

    task automatic release_res();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("after_release_valid", {31'd0, res_valid}, 32'd0);
        chk("after_release_ready", {31'd0, op_ready},  32'd1);
    endtask

    logic [7:0] opc_tab [11] = '{8'h2F, 8'h37, 8'h3F, 8'h07, 8'h0F, 8'h17, 8'h1F,
                                 8'h44, 8'h27, 8'h00, 8'hFF};

    initial begin
        reset = 1'b1; op_valid = 1'b0; res_ready = 1'b0;
        op_insn = '0; op_len = 2'd1; ip_in = '0; a_in = '0; f_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, op_ready},  32'd1);
        chk("rst_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_a",     {24'd0, a_out},     32'd0);
        chk("rst_f",     {24'd0, f_out},     32'd0);
        chk("rst_ip",    {16'd0, ip_out},    32'd0);
        chk("rst_tc",    {28'd0, tcycles},   32'd0);
        chk("rst_ill",   {31'd0, illegal},   32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        send(16'h002F, 2'd1, 16'h1000, 8'h5A, 8'h00);
        wait_res("cpl");
        chk("cpl_a_const", {24'd0, a_out}, 32'hA5);
        chk("cpl_f_const", {24'd0, f_out}, 32'h12);
        hold(10);
        release_res();

        send(16'hED44, 2'd2, 16'h2000, 8'h80, 8'h00);
        wait_res("neg80");
        chk("neg80_f_const", {24'd0, f_out}, 32'h87);
        chk("neg80_tc_const", {28'd0, tcycles}, 32'd8);
        release_res();

        send(16'hED44, 2'd2, 16'h2002, 8'h00, 8'hFF);
        wait_res("neg00");
        chk("neg00_f_const", {24'd0, f_out}, 32'h42);
        release_res();

        send(16'h0017, 2'd1, 16'h3000, 8'h80, 8'h01);
        wait_res("rla");
        chk("rla_a_const", {24'd0, a_out}, 32'h01);
        chk("rla_f_const", {24'd0, f_out}, 32'h01);
        res_ready = 1'b1;
        send(16'h003F, 2'd1, 16'h3001, 8'h28, 8'h01);
        res_ready = 1'b0;
        chk("b2b_no_valid", {31'd0, res_valid}, 32'd0);
        wait_res("b2b_ccf");
        release_res();

        send(16'h0027, 2'd1, 16'h4000, 8'h15, 8'h00);
        wait_res("op27");
`ifndef Z80_ACCOP_DAA_EN
        chk("op27_ill_const", {31'd0, illegal}, 32'd1);
        chk("op27_a_const",   {24'd0, a_out},   32'h15);
`endif
        release_res();
`ifdef Z80_ACCOP_DAA_EN
        send(16'h0027, 2'd1, 16'h4001, 8'h9A, 8'h00);
        wait_res("daa9a");
        chk("daa_a_const", {24'd0, a_out}, 32'h00);
        chk("daa_f_const", {24'd0, f_out}, 32'h55);
        release_res();
`endif

        send(16'h0007, 2'd1, 16'hFFFF, 8'h81, 8'h00);
        wait_res("ipwrap");
        chk("ipwrap_const", {16'd0, ip_out}, 32'h0000);
        release_res();

        send(16'h0044, 2'd1, 16'h5000, 8'h10, 8'h00);
        wait_res("neg_badlen");
        release_res();

        send(16'hED44, 2'd2, 16'h6000, 8'h33, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_ready", {31'd0, op_ready},  32'd1);
        chk("midrst_valid", {31'd0, res_valid}, 32'd0);
        chk("midrst_a",     {24'd0, a_out},     32'd0);
        chk("midrst_f",     {24'd0, f_out},     32'd0);
        chk("midrst_ip",    {16'd0, ip_out},    32'd0);
        chk("midrst_tc",    {28'd0, tcycles},   32'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_pulse", {31'd0, res_valid}, 32'd0);
        end

        for (int i = 0; i < 60; i++) begin
            logic [7:0]  opc;
            logic [7:0]  pfx;
            logic [1:0]  len;
            opc = opc_tab[$urandom_range(0, 10)];
            pfx = 8'($urandom);
            len = 2'd1;
            if (opc == 8'h44) begin pfx = 8'hED; len = 2'd2; end
            if ($urandom_range(0, 7) == 0) len = (len == 2'd1) ? 2'd2 : 2'd1;
            send({pfx, opc}, len, 16'($urandom), 8'($urandom), 8'($urandom));
            wait_res("rand");
            hold($urandom_range(0, 3));
            release_res();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/z80_acc_op_unit.md
# z80_acc_op_unit

Multi-cycle execution unit for the Z80 accumulator/flag-only instructions: CPL, SCF, CCF, RLCA, RRCA, RLA, RRA and NEG, with DAA optional. It accepts one decoded instruction per handshake and models M1 T-state timing with a counter. It returns new A/F, the next IP and the T-state count, in the same form the z80fi instruction specs check. It sits between the core decoder and the register-file writeback.

## Interface
Parameters:
- M1_TCYCLES, 4, T-states per M1 opcode fetch; total latency = M1_TCYCLES × op_len.
- TC_W, 4, width of the tcycles counter/output; must hold 2×M1_TCYCLES.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  request valid.
- op_ready  out  1  unit can accept a request this cycle.
- op_insn  in  16  [7:0] = opcode, [15:8] = prefix (0xED for NEG, else ignored).
- op_len  in  2  instruction length: 1 unprefixed, 2 ED-prefixed.
- ip_in  in  16  IP of the instruction.
- a_in  in  8  accumulator in.
- f_in  in  8  flags in, {S,Z,5,H,3,PV,N,C}.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts result.
- a_out  out  8  new A.
- f_out  out  8  new F.
- ip_out  out  16  ip_in + op_len, modulo 2^16.
- tcycles  out  TC_W  T-states consumed.
- illegal  out  1  opcode not handled by this unit.

## Operation
- States: IDLE, EXEC, DONE.
- IDLE:
  - op_ready=1.
  - op_valid → latch inputs, compute result into registers, tcnt←1, go to EXEC.
- EXEC:
  - tcnt increments each clock.
  - When tcnt == M1_TCYCLES×op_len, go to DONE.
- DONE:
  - res_valid=1; outputs stable until res_ready.
  - res_ready → IDLE.
  - Also op_ready=res_ready; if op_valid is also high, accept the new request and go directly to EXEC (back-to-back, no bubble).
- Opcode results (S, Z, PV kept from f_in unless stated):
  - CPL 0x2F: A=~A; H=1, N=1; bits 5/3 and C kept.
  - SCF 0x37: C=1, H=0, N=0; 5/3 = A[5]/A[3].
  - CCF 0x3F: H=old C, C=~old C, N=0; 5/3 from A.
  - RLCA 0x07: A={A[6:0],A[7]}, C=A[7].
  - RRCA 0x0F: A={A[0],A[7:1]}, C=A[0].
  - RLA 0x17: A={A[6:0],Cin}, C=A[7].
  - RRA 0x1F: A={Cin,A[7:1]}, C=A[0].
  - All four rotates: H=0, N=0, 5/3 from result.
  - NEG ED 0x44 (op_len=2): r=0−A (8-bit); S=r[7], Z=(r==0), H=(A[3:0]!=0), PV=(A==0x80), N=1, C=(A!=0), 5/3 from r.
- Unhandled opcode, or a prefix/len mismatch:
  - illegal=1; A/F pass through unchanged.
  - ip_out and tcycles still computed normally.
- tcycles output = final tcnt value.

## Timing
- Reset values: state IDLE; op_ready=1; res_valid=0; a_out, f_out, ip_out, tcycles=0; illegal=0.
- Reset mid-EXEC or mid-DONE: pending result dropped, IDLE on the next edge, no res_valid pulse.
- Latency: accept edge to res_valid high = M1_TCYCLES×op_len cycles (4 for unprefixed, 8 for NEG at default).
- Inputs are sampled only on the accept edge; later changes have no effect.
- res_valid must not drop before res_ready. Outputs must not change while res_valid=1 and res_ready=0.

## Configuration
- Z80_ACCOP_DAA_EN defined: DAA 0x27 is supported.
  - Correction 0x06/0x60/0x66 chosen from H, C, A nibbles; subtract when N=1.
  - C = old C | (A>0x99); H follows the standard add/subtract nibble rule.
  - S, Z and 5/3 from the result; PV=even parity; N kept.
  - 4 T-states.
- Z80_ACCOP_DAA_EN undefined: 0x27 → illegal=1, A/F unchanged.

## Structure
- Shared package z80_accop_pkg:
  - state enum.
  - opcode constants (OP_CPL, OP_SCF, OP_CCF, OP_RLCA, OP_RRCA, OP_RLA, OP_RRA, OP_NEG, OP_DAA, PREFIX_ED).
  - flag bit index constants matching z80.vh FLAG_*_NUM.
- One combinational sub-module, z80_accop_compute: {insn, len, a, f} → {a, f, illegal}. The top level holds the FSM, counter and output registers.

## Test plan
- CPL, A=0x5A, F=0x00 → after 4 cycles a_out=0xA5, f_out=0x12, ip_out=ip_in+1, tcycles=4.
- NEG ED44, A=0x80, F=0x00 → after 8 cycles a_out=0x80, f_out=0x87, tcycles=8.
- NEG, A=0x00 → a_out=0x00, f_out=0x42 (Z, N; C=0).
- RLA, A=0x80, F=0x01 → a_out=0x01, f_out=0x01. Back-to-back CCF offered in the same DONE cycle as res_ready → accepted, no idle cycle.
- Hold res_ready=0 for 10 cycles in DONE → outputs stable. Assert reset mid-EXEC → next cycle op_ready=1, res_valid=0, outputs 0.
- Opcode 0x27, A=0x15, F=0x00 → a_out=0x15, illegal=1 without Z80_ACCOP_DAA_EN; with it defined (0x9A, F=0x00) → a_out=0x00, f_out=0x55. ip_in=0xFFFF, op_len=1 → ip_out=0x0000.
